// File: rtl/confreg_pkg.sv
// Shared register-map offsets, TIMER_CTRL bit positions, register selector type and
// the byte-lane merge helper for the SRAM-side configuration register block.
package confreg_pkg;

    localparam logic [15:0] CR_BASE        = 16'h0000;
    localparam logic [15:0] TIMER_OFF      = 16'h1000;
    localparam logic [15:0] TIMER_CMP_OFF  = 16'h1004;
    localparam logic [15:0] TIMER_CTRL_OFF = 16'h1008;
    localparam logic [15:0] LED_OFF        = 16'hF000;
    localparam logic [15:0] SWITCH_OFF     = 16'hF004;
    localparam logic [15:0] SIMU_OFF       = 16'hF008;
    localparam logic [15:0] UART_OFF       = 16'hF010;

    localparam int CR_NUM   = 8;
    localparam int EN_BIT   = 0;
    localparam int IE_BIT   = 1;
    localparam int PEND_BIT = 2;

    typedef enum logic [3:0] {
        SEL_NONE,
        SEL_CR,
        SEL_TIMER,
        SEL_CMP,
        SEL_CTRL,
        SEL_LED,
        SEL_SWITCH,
        SEL_SIMU,
        SEL_UART
    } reg_sel_e;

    // Offsets arrive word-aligned; CR0-CR7 occupy the first 32 bytes.
    function automatic reg_sel_e decode_offset(input logic [15:0] off, input logic uart_mapped);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (off[15:5] == CR_BASE[15:5]) begin
            sel = SEL_CR;
        end else begin
            case (off)
                TIMER_OFF:      sel = SEL_TIMER;
                TIMER_CMP_OFF:  sel = SEL_CMP;
                TIMER_CTRL_OFF: sel = SEL_CTRL;
                LED_OFF:        sel = SEL_LED;
                SWITCH_OFF:     sel = SEL_SWITCH;
                SIMU_OFF:       sel = SEL_SIMU;
                UART_OFF:       sel = uart_mapped ? SEL_UART : SEL_NONE;
                default:        sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wen);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = wen[i] ? wdata[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/confreg_timer.sv
// Free-running compare timer: counter, compare value, EN/IE/PEND control and the
// level interrupt. CPU writes beat the increment; a hardware PEND set beats W1C.
module confreg_timer
    import confreg_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        timer_we_i,
    input  logic        cmp_we_i,
    input  logic        ctrl_we_i,
    input  logic [3:0]  wen_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] timer_o,
    output logic [31:0] cmp_o,
    output logic [2:0]  ctrl_o,
    output logic        timer_int_o
);

    logic [31:0] timer_q, timer_d;
    logic [31:0] cmp_q, cmp_d;
    logic        en_q, en_d;
    logic        ie_q, ie_d;
    logic        pend_q, pend_d;
    logic        match;

    assign match = en_q && (timer_q == cmp_q);

    always_comb begin
        timer_d = timer_q;
        if (timer_we_i) begin
            timer_d = byte_merge(timer_q, wdata_i, wen_i);
        end else if (en_q) begin
            timer_d = timer_q + 32'd1;
        end
    end

    assign cmp_d = cmp_we_i ? byte_merge(cmp_q, wdata_i, wen_i) : cmp_q;

    always_comb begin
        en_d   = en_q;
        ie_d   = ie_q;
        pend_d = pend_q;
        if (ctrl_we_i && wen_i[0]) begin
            en_d = wdata_i[EN_BIT];
            ie_d = wdata_i[IE_BIT];
            if (wdata_i[PEND_BIT]) begin
                pend_d = 1'b0;
            end
        end
        // The set is applied last so it overrides a same-cycle clear.
        if (match) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer_q <= '0;
            cmp_q   <= '0;
            en_q    <= 1'b0;
            ie_q    <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            timer_q <= timer_d;
            cmp_q   <= cmp_d;
            en_q    <= en_d;
            ie_q    <= ie_d;
            pend_q  <= pend_d;
        end
    end

    assign timer_o     = timer_q;
    assign cmp_o       = cmp_q;
    assign ctrl_o      = {pend_q, ie_q, en_q};
    assign timer_int_o = pend_q & ie_q;

endmodule

// File: rtl/sram_confreg_slave.sv
// Data-SRAM responder exposing scratch, timer, LED, switch and SIMU registers with a
// one-cycle read latency. Optional UART TX strobe register enabled by CONFREG_UART_EN.
module sram_confreg_slave
    import confreg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hBFAF_0000,
    parameter logic [31:0] SIMU_FLAG = 32'hFFFF_FFFF,
    parameter int          LED_W     = 16,
    parameter int          SW_W      = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             data_sram_en,
    input  logic [3:0]       data_sram_wen,
    input  logic [31:0]      data_sram_addr,
    input  logic [31:0]      data_sram_wdata,
    output logic [31:0]      data_sram_rdata,
    output logic [LED_W-1:0] led,
    output logic             timer_int,
`ifdef CONFREG_UART_EN
    output logic             uart_valid,
    output logic [7:0]       uart_data,
`endif
    input  logic [SW_W-1:0]  switch
);

`ifdef CONFREG_UART_EN
    localparam logic UART_MAPPED = 1'b1;
`else
    localparam logic UART_MAPPED = 1'b0;
`endif

    logic [15:0]      off;
    logic [2:0]       cr_idx;
    logic             base_hit;
    logic             wr_req;
    logic             rd_req;
    reg_sel_e         sel;
    logic             unused_addr_bits;

    logic [31:0]      cr_q [CR_NUM];
    logic [31:0]      cr_d [CR_NUM];
    logic [LED_W-1:0] led_q, led_d;
    logic [SW_W-1:0]  sw_meta_q, sw_sync_q;
    logic [31:0]      rdata_q, rdata_d;
    logic [31:0]      rd_val;

    logic [31:0]      tmr_timer;
    logic [31:0]      tmr_cmp;
    logic [2:0]       tmr_ctrl;

    // Byte offset bits are don't-care: all registers are word-addressed.
    assign off              = {data_sram_addr[15:2], 2'b00};
    assign cr_idx           = data_sram_addr[4:2];
    assign unused_addr_bits = ^data_sram_addr[1:0];
    assign base_hit         = data_sram_en && (data_sram_addr[31:16] == BASE_ADDR[31:16]);
    assign sel              = base_hit ? decode_offset(off, UART_MAPPED) : SEL_NONE;
    assign wr_req           = (data_sram_wen != 4'b0000);
    assign rd_req           = data_sram_en && (data_sram_wen == 4'b0000);

    confreg_timer u_timer (
        .clk         (clk),
        .resetn      (resetn),
        .timer_we_i  (wr_req && (sel == SEL_TIMER)),
        .cmp_we_i    (wr_req && (sel == SEL_CMP)),
        .ctrl_we_i   (wr_req && (sel == SEL_CTRL)),
        .wen_i       (data_sram_wen),
        .wdata_i     (data_sram_wdata),
        .timer_o     (tmr_timer),
        .cmp_o       (tmr_cmp),
        .ctrl_o      (tmr_ctrl),
        .timer_int_o (timer_int)
    );

    always_comb begin
        for (int i = 0; i < CR_NUM; i++) begin
            cr_d[i] = cr_q[i];
        end
        if (wr_req && (sel == SEL_CR)) begin
            cr_d[cr_idx] = byte_merge(cr_q[cr_idx], data_sram_wdata, data_sram_wen);
        end
    end

    always_comb begin
        led_d = led_q;
        if (wr_req && (sel == SEL_LED)) begin
            led_d = LED_W'(byte_merge(32'(led_q), data_sram_wdata, data_sram_wen));
        end
    end

    // Read mux sees only pre-edge register values, so same-cycle updates are not visible.
    always_comb begin
        rd_val = '0;
        case (sel)
            SEL_CR:     rd_val = cr_q[cr_idx];
            SEL_TIMER:  rd_val = tmr_timer;
            SEL_CMP:    rd_val = tmr_cmp;
            SEL_CTRL:   rd_val = 32'(tmr_ctrl);
            SEL_LED:    rd_val = 32'(led_q);
            SEL_SWITCH: rd_val = 32'(sw_sync_q);
            SEL_SIMU:   rd_val = SIMU_FLAG;
            default:    rd_val = '0;
        endcase
    end

    assign rdata_d = rd_req ? rd_val : rdata_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < CR_NUM; i++) begin
                cr_q[i] <= '0;
            end
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            rdata_q   <= '0;
        end else begin
            for (int i = 0; i < CR_NUM; i++) begin
                cr_q[i] <= cr_d[i];
            end
            led_q     <= led_d;
            sw_meta_q <= switch;
            sw_sync_q <= sw_meta_q;
            rdata_q   <= rdata_d;
        end
    end

`ifdef CONFREG_UART_EN
    logic       uart_valid_q, uart_valid_d;
    logic [7:0] uart_data_q, uart_data_d;

    assign uart_valid_d = wr_req && (sel == SEL_UART) && data_sram_wen[0];
    assign uart_data_d  = uart_valid_d ? data_sram_wdata[7:0] : uart_data_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            uart_valid_q <= 1'b0;
            uart_data_q  <= '0;
        end else begin
            uart_valid_q <= uart_valid_d;
            uart_data_q  <= uart_data_d;
        end
    end

    assign uart_valid = uart_valid_q;
    assign uart_data  = uart_data_q;
`endif

    assign data_sram_rdata = rdata_q;
    assign led             = led_q;

endmodule

// File: doc/sram_confreg_slave.md
Name: sram_confreg_slave

Overview:
- Responder end of the CPU data-SRAM interface: a memory-mapped configuration/peripheral register block.
- Serves single-cycle-issue, fixed one-cycle-latency reads and byte-lane writes.
- Provides scratch registers, a compare timer with an interrupt that feeds one CPU `int` bit, LED output and a synchronised switch input.
- Sits in the SoC beside the data RAM; the SoC address decoder routes matching `data_sram_*` traffic here.

Parameters:
- BASE_ADDR, 32'hBFAF_0000: upper 16 bits select this block; the decode compares addr[31:16] against BASE_ADDR[31:16].
- SIMU_FLAG, 32'hFFFF_FFFF: constant value returned by the SIMU register.
- LED_W, 16: LED register width.
- SW_W, 8: switch input width.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- data_sram_en  in  1  request valid this cycle
- data_sram_wen  in  4  byte write enables; 0 = read
- data_sram_addr  in  32  byte address
- data_sram_wdata  in  32  write data
- data_sram_rdata  out  32  read data, valid the cycle after the request
- led  out  LED_W  LED register contents
- switch  in  SW_W  asynchronous switch inputs
- timer_int  out  1  level interrupt to CPU

Behaviour:
- Reset: asynchronous, active-low, on resetn; the clock is clk. All registers are 0, including rdata, led, timer_int and the sync flops.
- Register map, offsets from addr[15:0]; all registers are 32-bit unless noted:
  - 0x0000-0x001C: CR0-CR7 scratch, RW.
  - 0x1000: TIMER, RW.
  - 0x1004: TIMER_CMP, RW.
  - 0x1008: TIMER_CTRL, RW:
    - bit0 EN.
    - bit1 IE.
    - bit2 PEND: read 1 when set; writing 1 clears it (W1C).
    - Other bits read 0.
  - 0xF000: LED, RW; upper bits read 0.
  - 0xF004: SWITCH, RO.
  - 0xF008: SIMU, RO, returns SIMU_FLAG.
- Hit: data_sram_en & (addr[31:16] == BASE_ADDR[31:16]) & offset in the map.
- Unmapped or misdirected requests:
  - Writes are ignored.
  - Reads return 0.
  - No error is signalled.
- Decode ignores addr[1:0].
- Read timing:
  - When en is high and wen == 0 in cycle N, rdata is updated at the N→N+1 edge.
  - rdata returns the register value sampled before any same-cycle update.
  - rdata holds its value while en is low.
- Write timing:
  - When en is high and wen != 0, each set wen[i] writes wdata byte i at the clock edge.
  - For RO registers, writes are ignored.
  - A write request does not update rdata.
- Timer:
  - While EN = 1, TIMER increments by 1 per cycle, wrapping 0xFFFF_FFFF → 0.
  - A CPU write to any TIMER byte has priority over the increment that cycle. Written bytes take wdata; unwritten bytes keep their old value and do not increment.
  - While EN = 1 and TIMER == TIMER_CMP (pre-increment value), PEND is set.
  - A hardware set of PEND and a CPU W1C in the same cycle: set wins.
  - timer_int = PEND & IE, driven from flops with no combinational path from inputs.
- SWITCH is the output of a 2-flop synchroniser. A CPU read sees a switch change no earlier than 2 edges after it and, counting the read-latency edge, 3 edges after it.
- Back-to-back requests are allowed every cycle. There are no stalls and no busy signal.

Optional Feature:
- Macro: CONFREG_UART_EN.
- Defined:
  - Adds ports `uart_valid` (out, 1) and `uart_data` (out, 8).
  - A write with wen[0] = 1 to offset 0xF010 drives uart_data = wdata[7:0] and uart_valid = 1 for exactly one cycle after the edge.
  - Reads of 0xF010 return 0.
- Undefined: the ports are absent; 0xF010 is unmapped.

Decomposition:
- Package `confreg_pkg`:
  - Offset constants: CR_BASE, TIMER_OFF, TIMER_CMP_OFF, TIMER_CTRL_OFF, LED_OFF, SWITCH_OFF, SIMU_OFF, UART_OFF.
  - TIMER_CTRL bit indices: EN_BIT = 0, IE_BIT = 1, PEND_BIT = 2.
  - A byte-merge function taking (old, wdata, wen).
- Sub-module `confreg_timer`:
  - Contains the counter, compare, CTRL and the PEND set/clear priority.
  - Takes per-register write strobes plus wen/wdata.
  - Exports the values and timer_int.

Test Plan:
- Reset then read each mapped register → 0, except SIMU = 0xFFFF_FFFF; led = 0 and timer_int = 0.
- Write CR3 = 0x1122_3344 (wen = F), then write 0xAABB_CCDD with wen = 4'b0101; read CR3 → 0x11BB_33DD, returned the cycle after the read request.
- Write TIMER_CMP = 10, TIMER = 0, CTRL = 0x3 → PEND is set as TIMER reaches 11; timer_int rises the cycle after the match edge and stays high.
- With PEND = 1 and the timer stopped, write CTRL = 0x7 → PEND clears (read 0x3). Also write CTRL with bit2 = 1 in the exact match cycle → PEND stays 1.
- Drive switch = 0xA5 at cycle 0 and read SWITCH every cycle → rdata first shows 0x000000A5 no earlier than the third edge after the change. Also read addr 0xBFAF_2000 → 0, and addr 0x1FAF_0000 → 0 with no CR side effect.
- CONFREG_UART_EN defined: write 0x41 to 0xF010 → uart_valid pulses one cycle with uart_data = 0x41. Back-to-back writes → two pulses with no gap.
